// File: rtl/dp_demod_pkg.sv
// Shared types and constants for the dual-mode AM/FM demodulator.
// Holds the FM FSM state enum, sample/output width, the FM period-counter
// ceiling and the signed output saturation limits.
package dp_demod_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned CNT_W    = 16;

  localparam logic [CNT_W-1:0]           CNT_MAX = 16'hFFFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } fm_state_e;

endpackage

// File: rtl/dp_demod_am_boxcar.sv
// am_boxcar: N_AVG-deep moving average of rectified samples.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         drop history, sum, pointer and the pending valid
//   rect          rectified sample (unsigned, RW bits)
//   rect_vld      rect is valid this cycle
//   avg           sum / N_AVG (slice of the sum register)
//   avg_vld       avg valid, one cycle per accepted rect
module am_boxcar #(
  parameter int unsigned N_AVG = 16,
  parameter int unsigned RW    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [RW-1:0] rect,
  input  logic          rect_vld,
  output logic [RW-1:0] avg,
  output logic          avg_vld
);

  localparam int unsigned AW = (N_AVG > 1) ? $clog2(N_AVG) : 1;
  localparam int unsigned SW = RW + AW;

  logic [RW-1:0] hist_q [N_AVG];
  logic [AW-1:0] ptr_q;
  logic [SW-1:0] sum_q;
  logic          vld_q;

  // Running sum: add the newest sample, retire the one it overwrites.
  // Intermediate may wrap; the final sum always fits SW bits.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < int'(N_AVG); i++) hist_q[i] <= '0;
      ptr_q <= '0;
      sum_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= rect_vld;
      if (rect_vld) begin
        sum_q         <= sum_q + SW'(rect) - SW'(hist_q[ptr_q]);
        hist_q[ptr_q] <= rect;
        ptr_q         <= (ptr_q == AW'(N_AVG - 1)) ? '0 : ptr_q + AW'(1);
      end
    end
  end

  assign avg     = RW'(sum_q >> AW);
  assign avg_vld = vld_q;

endmodule

// File: rtl/dp_demod.sv
// dp_demod: AM (rectify + boxcar) or FM (period measurement) demodulator.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_data        signed modulated sample, qualified by val_in
//   c_fm_am       mode select, 1 = FM, 0 = AM (registered internally)
//   nom_period    nominal FM carrier period in valid samples
//   o_data        demodulated value, held between results
//   val_out       one-cycle pulse per result
//   ovf           FM period counter sitting at its ceiling
module dp_demod
  import dp_demod_pkg::*;
#(
  parameter int unsigned N_AVG = 16,
  parameter int unsigned W     = SAMPLE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [W-1:0]  i_data,
  input  logic                 val_in,
  input  logic                 c_fm_am,
  input  logic [CNT_W-1:0]     nom_period,
  output logic signed [W-1:0]  o_data,
  output logic                 val_out,
  output logic                 ovf
);

  localparam int unsigned RW = W - 1;
  localparam int unsigned DW = CNT_W + 1;

  // Mode register; a change flushes both datapaths in the same edge.
  logic mode_q;
  logic mode_chg_c;
  logic am_take_c;
  logic fm_take_c;

  always_ff @(posedge clk) begin
    mode_q <= c_fm_am;
  end

  assign mode_chg_c = (c_fm_am != mode_q);
  assign am_take_c  = val_in && !mode_q && !mode_chg_c;
  assign fm_take_c  = val_in &&  mode_q && !mode_chg_c;

  // AM stage 1: absolute value, most-negative input clamps to full scale.
  logic [RW-1:0] rect_c;
  logic [RW-1:0] rect_q;
  logic          rect_vld_q;

  always_comb begin
    rect_c = RW'(i_data);
    if (i_data == W'(SAT_MIN)) rect_c = RW'(SAT_MAX);
    else if (i_data[W-1])      rect_c = RW'(-i_data);
  end

  always_ff @(posedge clk) begin
    if (rst || mode_chg_c) begin
      rect_q     <= '0;
      rect_vld_q <= 1'b0;
    end else begin
      rect_vld_q <= am_take_c;
      if (am_take_c) rect_q <= rect_c;
    end
  end

  // AM stage 2: moving average.
  logic [RW-1:0] avg;
  logic          avg_vld;

  am_boxcar #(
    .N_AVG (N_AVG),
    .RW    (RW)
  ) u_boxcar (
    .clk      (clk),
    .rst      (rst),
    .clear    (mode_chg_c),
    .rect     (rect_q),
    .rect_vld (rect_vld_q),
    .avg      (avg),
    .avg_vld  (avg_vld)
  );

  // FM: rising zero crossing on consecutive valid samples.
  fm_state_e        state_q;
  logic             prev_neg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_at_q;
  logic             cross_q;
  logic             cross_c;

  assign cross_c = fm_take_c && prev_neg_q && !i_data[W-1];

  // FM FSM and period counter; the first crossing only arms measurement.
  always_ff @(posedge clk) begin
    if (rst || mode_chg_c) begin
      state_q    <= ST_IDLE;
      prev_neg_q <= 1'b0;
      cnt_q      <= '0;
      cnt_at_q   <= '0;
      cross_q    <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      cross_q <= 1'b0;
      if (fm_take_c) begin
        prev_neg_q <= i_data[W-1];
        if (cross_c) begin
          state_q  <= ST_MEASURE;
          cnt_q    <= CNT_W'(1);
          cnt_at_q <= cnt_q;
          cross_q  <= (state_q == ST_MEASURE);
          ovf      <= 1'b0;
        end else if (state_q == ST_MEASURE && cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + CNT_W'(1);
          ovf   <= (cnt_q == CNT_MAX - CNT_W'(1));
        end
      end
    end
  end

  // FM result: nominal minus measured period, clamped to the output range.
  logic signed [DW-1:0] fm_diff_c;
  logic signed [W-1:0]  fm_sat_c;

  always_comb begin
    fm_diff_c = $signed({1'b0, nom_period}) - $signed({1'b0, cnt_at_q});
    fm_sat_c  = W'(fm_diff_c);
    if (fm_diff_c > $signed(DW'(SAT_MAX)))      fm_sat_c = W'(SAT_MAX);
    else if (fm_diff_c < $signed(DW'(SAT_MIN))) fm_sat_c = W'(SAT_MIN);
  end

  // Output register; o_data holds across idle cycles and mode changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_data  <= '0;
      val_out <= 1'b0;
    end else if (mode_chg_c) begin
      val_out <= 1'b0;
    end else begin
      val_out <= avg_vld || cross_q;
      if (avg_vld)      o_data <= $signed({1'b0, avg});
      else if (cross_q) o_data <= fm_sat_c;
    end
  end

endmodule

// File: tb/tb_dp_demod.sv
// Scoreboard bench for dp_demod: stimulus pushes expected (value, cycle)
// pairs, a negedge monitor pops and checks every val_out pulse.
module tb_dp_demod;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] i_data = '0;
  logic               val_in = 1'b0;
  logic               c_fm_am = 1'b0;
  logic [15:0]        nom_period = 16'd20;
  logic signed [15:0] o_data;
  logic               val_out;
  logic               ovf;

  dp_demod #(.N_AVG(16), .W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .val_in     (val_in),
    .c_fm_am    (c_fm_am),
    .nom_period (nom_period),
    .o_data     (o_data),
    .val_out    (val_out),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every val_out must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (val_out === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_val_out: got o_data %0d at cycle %0d expected no output",
                   o_data, cyc);
        end else begin
          mon_e = q.pop_front();
          check("o_data", int'(o_data), mon_e.data);
          check("latency_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic drive(input logic signed [15:0] d);
    @(posedge clk);
    #1;
    i_data = d;
    val_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      val_in = 1'b0;
    end
  endtask

  task automatic expect_at(input int data, input int lat);
    exp_t e;
    e.data = data;
    e.cyc  = cyc + lat;
    q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst    = 1'b1;
    val_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_o_data", int'(o_data), 0);
    check("rst_val_out", int'(val_out), 0);
    check("rst_ovf", int'(ovf), 0);
  endtask

  // AM: alternate samples a/b whose magnitude is rect; avg fills over 16.
  task automatic am_run(input logic signed [15:0] a, input logic signed [15:0] b,
                        input int rect, input int n, input int gap);
    for (int k = 1; k <= n; k++) begin
      drive((k % 2 == 1) ? a : b);
      expect_at(((k < 16 ? k : 16) * rect) >> 4, 3);
      if (gap > 0) idle(gap);
    end
    idle(1);
  endtask

  // FM square wave starting high; crossing at start of each high block
  // after the first yields exp two cycles later.
  task automatic fm_run(input int hi, input int lo, input int periods,
                        input int exp, input int gap);
    for (int p = 0; p <= periods; p++) begin
      for (int j = 0; j < hi; j++) begin
        drive(16'sd8000);
        if (p >= 2 && j == 0) expect_at(exp, 2);
        if (gap > 0) idle(gap);
      end
      if (p < periods) begin
        for (int j = 0; j < lo; j++) begin
          drive(-16'sd8000);
          if (gap > 0) idle(gap);
        end
      end
    end
    idle(1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    // AM steady -1000: 62, 125, ... 1000
    am_run(-16'sd1000, -16'sd1000, 1000, 20, 0);
    idle(5);
    check("am_hold_o_data", int'(o_data), 1000);
    check("am_hold_val_out", int'(val_out), 0);

    // AM full-scale negative clamps to 32767
    do_reset();
    am_run(-16'sd32768, -16'sd32768, 32767, 20, 0);
    idle(5);
    check("am_sat_final", int'(o_data), 32767);

    // AM alternating sign with gaps
    do_reset();
    am_run(16'sd2000, -16'sd2000, 2000, 18, 1);
    idle(5);

    // Mode switch AM->FM with samples in flight: only 3 results survive
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      drive(-16'sd1000);
      if (k <= 3) expect_at((k * 1000) >> 4, 3);
    end
    @(posedge clk);
    #1;
    val_in  = 1'b0;
    c_fm_am = 1'b1;
    idle(6);
    @(posedge clk);
    #1;
    c_fm_am = 1'b0;
    idle(3);
    am_run(-16'sd1000, -16'sd1000, 1000, 4, 0);
    idle(5);
    check("am_restart_o_data", int'(o_data), 250);

    // FM period 20, nominal 20
    c_fm_am    = 1'b1;
    nom_period = 16'd20;
    do_reset();
    fm_run(10, 10, 4, 0, 0);
    idle(3);

    // FM period 25 -> -5
    do_reset();
    fm_run(13, 12, 3, -5, 0);
    idle(3);

    // FM with 50% valid duty
    do_reset();
    fm_run(10, 10, 3, 0, 1);
    idle(3);

    // FM positive saturation, then reset aborting a pending result
    do_reset();
    nom_period = 16'd40000;
    fm_run(10, 10, 2, 32767, 0);
    idle(3);
    check("fm_sat_hi_hold", int'(o_data), 32767);
    for (int j = 0; j < 10; j++) drive(-16'sd8000);
    drive(16'sd8000);
    do_reset();
    nom_period = 16'd20;
    fm_run(10, 10, 3, 0, 0);
    idle(3);

    // FM counter saturation and negative output clamp
    do_reset();
    nom_period = 16'd100;
    drive(-16'sd100);
    drive(16'sd100);
    for (int k = 1; k <= 70000; k++) begin
      drive(16'sd100);
      if (k == 65534) check("ovf_before_sat", int'(ovf), 0);
      if (k == 65535) check("ovf_at_sat", int'(ovf), 1);
      if (k == 70000) check("ovf_held", int'(ovf), 1);
    end
    drive(-16'sd100);
    drive(16'sd100);
    expect_at(-32768, 2);
    idle(1);
    check("ovf_cleared", int'(ovf), 0);
    idle(5);

    check("scoreboard_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dp_demod.md
DP_DEMOD -- requirements
Module: dp_demod

Interface
REQ-001 SHALL have parameter N_AVG, default 16, AM boxcar length (power of 2, 2..64).
REQ-002 SHALL have parameter W, default 16, sample and output width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state rising-edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port i_data, input, 16 signed, modulated sample.
REQ-006 SHALL have port val_in, input, 1, i_data valid strobe; gaps allowed.
REQ-007 SHALL have port c_fm_am, input, 1, mode select: 1 = FM, 0 = AM.
REQ-008 SHALL have port nom_period, input, 16 unsigned, carrier period in valid samples.
REQ-009 SHALL have port o_data, output, 16 signed, demodulated value.
REQ-010 SHALL have port val_out, output, 1, o_data valid, one-cycle pulse per result.
REQ-011 SHALL have port ovf, output, 1, FM period counter saturated.

Function
REQ-012 SHALL process only samples with val_in=1; cycles with val_in=0 SHALL NOT change any count, buffer or sum.
REQ-013 AM rectify: rect = |i_data|; -32768 SHALL saturate to 32767; rect is 15-bit unsigned.
REQ-014 AM boxcar: circular buffer of N_AVG rect values, with write pointer wrapping N_AVG-1 -> 0; running sum updated as sum + rect - buf[ptr]; sum width 15+log2(N_AVG), no overflow.
REQ-015 AM output: o_data = {0, sum >> log2(N_AVG)}, never negative.
REQ-016 AM latency: val_out SHALL assert exactly 3 cycles after the accepting val_in cycle (rectify reg, sum reg, output reg).
REQ-017 FM rising crossing: previous valid sample < 0 and current valid sample >= 0.
REQ-018 FM FSM states: IDLE (no crossing seen yet) and MEASURE. IDLE -> MEASURE on the first crossing, with no output. MEASURE stays in MEASURE on each crossing and emits a result.
REQ-019 FM counter cnt counts valid samples since the last crossing. It is set to 1 on each crossing, increments by 1 per valid sample, and saturates at 65535.
REQ-020 ovf SHALL be high while cnt = 65535 in MEASURE. It SHALL clear on the cycle the next crossing is registered.
REQ-021 FM result: o_data = nom_period - cnt_at_crossing, computed at 17 bits signed and saturated to [-32768, 32767].
REQ-022 FM latency: val_out SHALL assert exactly 2 cycles after the val_in of the crossing sample.
REQ-023 c_fm_am SHALL be registered internally. When the registered value changes: buffer, sum and ptr SHALL clear, the FSM SHALL go to IDLE, cnt SHALL go to 0, and all in-flight valids SHALL be dropped (no val_out from the old mode).
REQ-024 o_data SHALL hold its last value while val_out=0.

Reset
REQ-025 On rst=1 at a clock edge: o_data=0, val_out=0, ovf=0, FSM=IDLE, cnt=0, sum=0, ptr=0, all buffer entries 0, previous-sign register = non-negative, pipeline valids 0.
REQ-026 rst asserted mid-operation SHALL abort any pending result; no val_out SHALL occur in the cycle after rst.

Structure
REQ-027 Package dp_demod_pkg SHALL hold the FSM state enum, sample/output width constants, the cnt maximum (65535), and the saturation limits.
REQ-028 The AM moving average SHALL be a sub-module am_boxcar (rect in, valid in, clear in, average out, valid out); the FM FSM and counter SHALL stay in dp_demod.

Verification
REQ-029 AM: c_fm_am=0, N_AVG=16, i_data=-1000 every cycle -> first val_out 3 cycles later with o_data=62, then 125, ...; 16th output and after = 1000.
REQ-030 AM saturation: i_data=-32768 continuous -> steady o_data=32767.
REQ-031 FM: square wave, 10 samples at +8000 then 10 at -8000, nom_period=20 -> no output at the first crossing, then o_data=0 at every crossing, 2 cycles after it. Period 25 -> o_data=-5.
REQ-032 FM gaps: same 20-sample wave with val_in at 50% duty -> o_data=0. Result timing follows the crossing sample's val_in per REQ-022.
REQ-033 FM overflow: nom_period=100; one crossing, then 70000 valid samples of +100, then a crossing -> ovf rises when cnt hits 65535, o_data=-32768 at the crossing, ovf clears.
REQ-034 Mode switch mid-stream -> no val_out from the old mode and AM sum restarts at 0. One-cycle rst mid-stream -> all outputs 0 the next cycle and the FSM back in IDLE.
